// File: rtl/blob_box_streamer_pkg.sv
// Shared definitions for blob_box_streamer: box field widths, record constants
// and the streamer FSM state encoding.
// Optional feature: BOX_STREAM_CHECKSUM_EN adds the CHK state (XOR checksum byte).
package blob_box_streamer_pkg;

    localparam int V_BITS    = 9;                      // top / bottom row fields
    localparam int H_BITS    = 10;                     // left / right column fields
    localparam int BOX_W     = 2 * V_BITS + 2 * H_BITS; // 38-bit packed box
    localparam int BOX_BYTES = 5;                      // {2'b00, box} sent as 5 bytes

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Field view of one packed box entry.
    typedef struct packed {
        logic [V_BITS-1:0] top;
        logic [V_BITS-1:0] bottom;
        logic [H_BITS-1:0] left;
        logic [H_BITS-1:0] right;
    } box_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_FRAME = 3'd2,
        ST_COUNT = 3'd3,
        ST_BOX   = 3'd4
`ifdef BOX_STREAM_CHECKSUM_EN
      , ST_CHK   = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/blob_box_streamer_pingpong_buf.sv
// box_pingpong_buf: two MAX_BOXES-deep box banks. The write bank collects the
// current frame; swap_i hands it to the reader and latches its count, clear_i
// throws the write bank away. A write in the same cycle as swap/clear belongs
// to the frame being closed.
module box_pingpong_buf
    import blob_box_streamer_pkg::*;
#(
    parameter int MAX_BOXES = 15,
    parameter int CNT_W     = $clog2(MAX_BOXES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [BOX_W-1:0] wr_data_i,
    input  logic             swap_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] rd_idx_i,
    output logic [BOX_W-1:0] rd_data_o,
    output logic [CNT_W-1:0] rd_cnt_o
);

    logic [BOX_W-1:0] bank0_q [MAX_BOXES];
    logic [BOX_W-1:0] bank1_q [MAX_BOXES];

    logic             wr_sel_q, wr_sel_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             wr_ok;

    // Entries past MAX_BOXES in one frame are dropped; the count saturates.
    assign wr_ok = wr_en_i && (wr_cnt_q < CNT_W'(MAX_BOXES));

    // Store accepted boxes in arrival order into the current write bank.
    // NOTE: bank storage has no reset; the counts gate every read, so stale entries are never streamed.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (wr_sel_q) bank1_q[wr_cnt_q] <= wr_data_i;
            else          bank0_q[wr_cnt_q] <= wr_data_i;
        end
    end

    // Next bank select and counts: swap on accepted frame, clear on dropped frame.
    // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q + CNT_W'(wr_ok);
        if (swap_i) begin
            wr_sel_d = ~wr_sel_q;
            rd_cnt_d = wr_cnt_q + CNT_W'(wr_ok);
            wr_cnt_d = '0;
        end else if (clear_i) begin
            wr_cnt_d = '0;
        end
    end

    // Bank select and count registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_sel_q <= wr_sel_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    assign rd_data_o = wr_sel_q ? bank0_q[rd_idx_i] : bank1_q[rd_idx_i];
    assign rd_cnt_o  = rd_cnt_q;

endmodule

// File: rtl/blob_box_streamer.sv
// blob_box_streamer: buffers per-frame bounding boxes in a ping-pong store and
// streams each closed frame as a byte record on a valid/ready port:
// SYNC_BYTE, frame counter, box count, 5 bytes per box (MSB first).
// Optional feature: define BOX_STREAM_CHECKSUM_EN to append an XOR checksum
// of all bytes after SYNC_BYTE.
module blob_box_streamer
    import blob_box_streamer_pkg::*;
#(
    parameter int         MAX_BOXES = 15,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic             app_clk,
    input  logic             app_rst_n,
    input  logic             box_wr,
    input  logic [BOX_W-1:0] box_data,
    input  logic             frame_end,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_drop
);

    localparam int CNT_W = $clog2(MAX_BOXES + 1);
`ifdef BOX_STREAM_CHECKSUM_EN
    localparam state_e REC_END = ST_CHK;
`else
    localparam state_e REC_END = ST_IDLE;
`endif

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       box_idx_q, box_idx_d;
    logic [2:0]             byte_idx_q, byte_idx_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic [7:0]             rec_frame_q, rec_frame_d;  // counter value carried by this record
    logic                   frame_drop_q, frame_drop_d;
    logic [CNT_W-1:0]       rd_cnt;
    logic [BOX_W-1:0]       rd_data;
    logic [BOX_BYTES*8-1:0] box_word;
    logic [7:0]             box_byte;
    logic                   accept, drop, hs, last_box;

    assign accept     = frame_end && (state_q == ST_IDLE);
    assign drop       = frame_end && (state_q != ST_IDLE);
    assign tx_valid   = (state_q != ST_IDLE);
    assign busy       = tx_valid;
    assign hs         = tx_valid && tx_ready;
    assign last_box   = (box_idx_q + CNT_W'(1)) == rd_cnt;
    assign frame_drop = frame_drop_q;
    assign box_word   = {{(BOX_BYTES*8-BOX_W){1'b0}}, rd_data};

    box_pingpong_buf #(
        .MAX_BOXES (MAX_BOXES),
        .CNT_W     (CNT_W)
    ) u_buf (
        .clk       (app_clk),
        .rst_n     (app_rst_n),
        .wr_en_i   (box_wr),
        .wr_data_i (box_data),
        .swap_i    (accept),
        .clear_i   (drop),
        .rd_idx_i  (box_idx_q),
        .rd_data_o (rd_data),
        .rd_cnt_o  (rd_cnt)
    );

    // Pick the current byte of the box being sent, most significant first.
    always_comb begin
        case (byte_idx_q)
            3'd0:    box_byte = box_word[39:32];
            3'd1:    box_byte = box_word[31:24];
            3'd2:    box_byte = box_word[23:16];
            3'd3:    box_byte = box_word[15:8];
            default: box_byte = box_word[7:0];
        endcase
    end

`ifdef BOX_STREAM_CHECKSUM_EN
    logic [7:0] chk_q, chk_d;

    // Running XOR of every accepted record byte after SYNC_BYTE.
    always_comb begin
        chk_d = chk_q;
        if (accept) begin
            chk_d = '0;
        end else if (hs && (state_q != ST_SYNC) && (state_q != ST_CHK)) begin
            chk_d = chk_q ^ tx_data;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) chk_q <= '0;
        else            chk_q <= chk_d;
    end
`endif

    // Output byte is a pure function of registered state, so it holds during stalls.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_SYNC:  tx_data = SYNC_BYTE;
            ST_FRAME: tx_data = rec_frame_q;
            ST_COUNT: tx_data = 8'(rd_cnt);
            ST_BOX:   tx_data = box_byte;
`ifdef BOX_STREAM_CHECKSUM_EN
            ST_CHK:   tx_data = chk_q;
`endif
            default:  tx_data = 8'h00;
        endcase
    end

    // Next-state logic: record sequencing advances only on an accepted byte.
    always_comb begin
        state_d      = state_q;
        box_idx_d    = box_idx_q;
        byte_idx_d   = byte_idx_q;
        rec_frame_d  = rec_frame_q;
        frame_cnt_d  = frame_cnt_q + {7'd0, frame_end};
        frame_drop_d = drop;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_SYNC;
                    rec_frame_d = frame_cnt_q + 8'd1;
                    box_idx_d   = '0;
                    byte_idx_d  = '0;
                end
            end
            ST_SYNC:  if (hs) state_d = ST_FRAME;
            ST_FRAME: if (hs) state_d = ST_COUNT;
            ST_COUNT: if (hs) state_d = (rd_cnt == '0) ? REC_END : ST_BOX;
            ST_BOX: begin
                if (hs) begin
                    if (byte_idx_q == 3'(BOX_BYTES - 1)) begin
                        byte_idx_d = '0;
                        if (last_box) state_d = REC_END;
                        else          box_idx_d = box_idx_q + CNT_W'(1);
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
`ifdef BOX_STREAM_CHECKSUM_EN
            ST_CHK:   if (hs) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM and record-position registers; reset aborts any record in progress.
    always_ff @(posedge app_clk or negedge app_rst_n) begin
        if (!app_rst_n) begin
            state_q      <= ST_IDLE;
            box_idx_q    <= '0;
            byte_idx_q   <= '0;
            frame_cnt_q  <= '0;
            rec_frame_q  <= '0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            box_idx_q    <= box_idx_d;
            byte_idx_q   <= byte_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            rec_frame_q  <= rec_frame_d;
            frame_drop_q <= frame_drop_d;
        end
    end

endmodule

// File: tb/tb_blob_box_streamer.sv
// Self-checking bench for blob_box_streamer. A queue-based reference model
// builds each expected record from the list of boxes written in the frame and
// tracks busy/drop behaviour from the bytes it has seen consumed.
module tb_blob_box_streamer;

    localparam int         MAX_BOXES = 15;
    localparam logic [7:0] SYNC      = 8'hA5;
`ifdef BOX_STREAM_CHECKSUM_EN
    localparam int CHK_LEN = 1;
`else
    localparam int CHK_LEN = 0;
`endif

    logic        app_clk = 1'b0;
    logic        app_rst_n;
    logic        box_wr;
    logic [37:0] box_data;
    logic        frame_end;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_drop;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  exp_q[$];     // bytes still to be accepted from the current record
    logic [37:0] wr_list[$];   // boxes collected for the open frame
    logic [7:0]  got_q[$];     // bytes actually accepted from the DUT
    logic [7:0]  frame_cnt_m;
    logic        drop_pend;
    logic        stall_prev;
    logic [7:0]  stall_byte;

    blob_box_streamer #(
        .MAX_BOXES (MAX_BOXES),
        .SYNC_BYTE (SYNC)
    ) dut (
        .app_clk    (app_clk),
        .app_rst_n  (app_rst_n),
        .box_wr     (box_wr),
        .box_data   (box_data),
        .frame_end  (frame_end),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_drop (frame_drop)
    );

    always #5 app_clk = ~app_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected record for a closed frame, built from the box list.
    function automatic void build_record();
        logic [7:0]  rec[$];
        logic [39:0] w;
        rec.push_back(SYNC);
        rec.push_back(frame_cnt_m);
        rec.push_back(8'(wr_list.size()));
        foreach (wr_list[i]) begin
            w = {2'b00, wr_list[i]};
            for (int k = 4; k >= 0; k--) rec.push_back(w[8*k +: 8]);
        end
`ifdef BOX_STREAM_CHECKSUM_EN
        begin
            logic [7:0] x = 8'h00;
            for (int i = 1; i < rec.size(); i++) x ^= rec[i];
            rec.push_back(x);
        end
`endif
        foreach (rec[i]) exp_q.push_back(rec[i]);
    endfunction

    // One clock: compare outputs (at posedge+1), drive inputs, advance model.
    task automatic cycle(input logic wr, input logic [37:0] data, input logic fe, input logic rdy);
        logic busy_m;
        busy_m = (exp_q.size() > 0);
        check("tx_valid", 64'(tx_valid), 64'(busy_m));
        check("busy", 64'(busy), 64'(busy_m));
        check("frame_drop", 64'(frame_drop), 64'(drop_pend));
        if (busy_m) check("tx_data", 64'(tx_data), 64'(exp_q[0]));
        if (stall_prev) check("stall_hold", 64'(tx_data), 64'(stall_byte));

        box_wr = wr; box_data = data; frame_end = fe; tx_ready = rdy;

        stall_prev = busy_m && !rdy;
        if (busy_m) stall_byte = exp_q[0];
        if (busy_m && rdy) begin
            got_q.push_back(tx_data);
            void'(exp_q.pop_front());
        end
        if (wr && wr_list.size() < MAX_BOXES) wr_list.push_back(data);
        drop_pend = 1'b0;
        if (fe) begin
            frame_cnt_m++;
            if (!busy_m) build_record();
            else         drop_pend = 1'b1;
            wr_list.delete();
        end
        @(posedge app_clk); #1;
    endtask

    task automatic drain(input bit rnd);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            cycle(1'b0, '0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            guard++;
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        app_rst_n = 1'b0;
        box_wr = 1'b0; frame_end = 1'b0; tx_ready = 1'b0; box_data = '0;
        #1;
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_drop", 64'(frame_drop), 64'd0);
        exp_q.delete(); wr_list.delete();
        frame_cnt_m = 8'h00; drop_pend = 1'b0; stall_prev = 1'b0;
        @(posedge app_clk); #3;
        app_rst_n = 1'b1;
        @(posedge app_clk); #1;
    endtask

    function automatic logic [37:0] rnd_box();
        return 38'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [7:0] s1_exp [13];
        int nb;
        s1_exp = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h3F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        app_rst_n = 1'b0; box_wr = 1'b0; frame_end = 1'b0; tx_ready = 1'b0; box_data = '0;
        frame_cnt_m = 8'h00; drop_pend = 1'b0; stall_prev = 1'b0; stall_byte = 8'h00;
        @(posedge app_clk); #1;
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Two known boxes, always ready
        got_q.delete();
        cycle(1'b1, 38'h0_1234_5678, 1'b0, 1'b1);
        cycle(1'b1, 38'h3F_FFFF_FFFF, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        drain(1'b0);
        check("s1_len", 64'(got_q.size()), 64'(13 + CHK_LEN));
        for (int i = 0; i < 13 && i < got_q.size(); i++) check("s1_byte", 64'(got_q[i]), 64'(s1_exp[i]));

        // Empty frame
        do_reset();
        got_q.delete();
        cycle(1'b0, '0, 1'b1, 1'b1);
        drain(1'b0);
        check("s2_len", 64'(got_q.size()), 64'(3 + CHK_LEN));
        if (got_q.size() >= 3) begin
            check("s2_sync", 64'(got_q[0]), 64'h0A5);
            check("s2_frame", 64'(got_q[1]), 64'h01);
            check("s2_count", 64'(got_q[2]), 64'h00);
        end

        // Random back-pressure through one record
        got_q.delete();
        for (int i = 0; i < 6; i++) cycle(1'b1, rnd_box(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        drain(1'b1);
        check("s3_len", 64'(got_q.size()), 64'(3 + 30 + CHK_LEN));

        // Overflow: 20 writes, only 15 kept
        got_q.delete();
        for (int i = 0; i < 20; i++) cycle(1'b1, rnd_box(), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        drain(1'b0);
        check("s4_len", 64'(got_q.size()), 64'(3 + 75 + CHK_LEN));
        if (got_q.size() >= 3) check("s4_count", 64'(got_q[2]), 64'h0F);

        // Frame closed while busy is dropped; counter still advances
        do_reset();
        cycle(1'b1, rnd_box(), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, rnd_box(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        drain(1'b0);
        got_q.delete();
        cycle(1'b0, '0, 1'b1, 1'b1);
        drain(1'b0);
        if (got_q.size() >= 2) check("s5_frame", 64'(got_q[1]), 64'h03);
        else                   check("s5_len", 64'(got_q.size()), 64'd2);

        // Reset in the middle of the BOX bytes
        cycle(1'b1, rnd_box(), 1'b0, 1'b1);
        cycle(1'b1, rnd_box(), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        do_reset();
        got_q.delete();
        cycle(1'b1, rnd_box(), 1'b1, 1'b1);
        drain(1'b0);
        if (got_q.size() >= 2) check("s6_frame", 64'(got_q[1]), 64'h01);
        else                   check("s6_len", 64'(got_q.size()), 64'd2);

        // Random mix: overlapping frames, drops, back-pressure, counter wrap
        for (int f = 0; f < 300; f++) begin
            nb = $urandom_range(0, 5);
            for (int b = 0; b < nb; b++)
                cycle(1'b1, rnd_box(), 1'b0, 1'($urandom_range(0, 1)));
            cycle(1'($urandom_range(0, 1)), rnd_box(), 1'b1, 1'($urandom_range(0, 1)));
            for (int g = $urandom_range(0, 30); g > 0; g--)
                cycle(1'b0, '0, 1'b0, 1'($urandom_range(0, 3) != 0));
        end
        drain(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
